uart_loader: RTL
================

// Module: uart_loader
// PURPOSE
//  Receive side of the LOAD handshake. Execute sends 0xAA to the host; the host answers with a
//  word count followed by the program image. This block collects those bytes from uart_rx and
//  assembles them into 32-bit words. It writes each word to instruction memory, then sends a
//  one-byte ACK through uart_tx. It sits beside execute and is enabled while mode==1.
// PARAMETERS
//  ADDR_W       14         instruction-memory word-address width; MAX_WORDS = 2**ADDR_W
//  TIMEOUT_CYC  32'd5000000  idle cycles allowed between bytes while in LEN/DATA before ERR
// PORTS
//  clk          in   1        system clock
//  rstn         in   1        synchronous active-low reset
//  start        in   1        1-cycle pulse: aa_sent observed, begin load
//  rx_data      in   8        byte from uart_rx
//  rx_ready     in   1        1-cycle strobe, rx_data valid
//  ferr         in   1        uart_rx framing error, qualified by rx_ready
//  tx_busy      in   1        uart_tx busy
//  tx_start     out  1        1-cycle strobe to uart_tx
//  tx_data      out  8        byte to uart_tx
//  imem_we      out  1        instruction-memory write enable (1 cycle per word)
//  imem_addr    out  ADDR_W   word address
//  imem_wdata   out  32       assembled word
//  word_cnt     out  32       words written in current/last load
//  busy         out  1        high in LEN/DATA/ACK
//  done         out  1        high in DONE
//  err          out  1        high in ERR
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; byte index, length, shift reg and timeout counter all 0.
//  Reset mid-load: aborts at once, no further imem writes.
//  Byte order: MSB first. byte k (0..3) lands in word[31-8k -: 8].
//  States:
//   IDLE: on start -> LEN, clear byte idx/word_cnt/timeout.
//   LEN: take 4 bytes into len. After the 4th byte:
//        len==0 -> ACK; len>MAX_WORDS -> ERR; otherwise -> DATA.
//   DATA: take 4 bytes per word. The cycle after the 4th rx_ready, assert imem_we for one cycle
//        with imem_addr=word_cnt[ADDR_W-1:0] and the word on imem_wdata; word_cnt increments in
//        that same cycle. When the incremented word_cnt==len -> ACK.
//   ACK: wait while tx_busy. Once ~tx_busy, drive tx_start=1 for one cycle with
//        tx_data=LOADER_ACK, then -> DONE.
//   DONE: done=1 held. A new start -> LEN (restart).
//   ERR: err=1 held. A new start -> LEN. err and done are never both 1.
//  rx_ready with ferr=1 while in LEN/DATA -> ERR. The byte is discarded and nothing is written.
//  rx_ready while in IDLE/ACK/DONE/ERR: byte dropped, no state change.
//  start while busy: ignored.
//  Timeout: counter runs in LEN/DATA and clears on every rx_ready. Reaching TIMEOUT_CYC -> ERR.
//  rx_ready and the timeout expiry in the same cycle: the byte wins and the counter clears.
//  A 4th byte followed by rx_ready in the very next cycle is accepted; the assembler must not
//  stall.
//  tx_start is never asserted while tx_busy=1, and only once per load.
//  word_cnt stays valid after DONE/ERR until the next start.
// STRUCTURE
//  Package constant gains LOADER_ACK = 8'h55 and typedef enum logic [2:0]
//  {LD_IDLE, LD_LEN, LD_DATA, LD_ACK, LD_DONE, LD_ERR} loader_state_t.
//  Sub-module byte_assembler: 8->32 shift register with 2-bit index, a 1-cycle word_valid
//  pulse, and a clear input. It serves both the LEN and DATA phases.
// TESTING
//  1 start; bytes 00 00 00 02, 12 34 56 78, 9A BC DE F0 -> writes 0x12345678@0 and
//    0x9ABCDEF0@1, tx_data=0x55 once, done=1, word_cnt=2.
//  2 start; len bytes 00 00 00 00 -> no imem_we, ACK sent, done=1.
//  3 len = MAX_WORDS+1 -> err=1, no imem_we, tx_start never asserted.
//  4 ferr=1 on 3rd data byte -> err=1, word_cnt unchanged; a new start reloads cleanly.
//  5 stall TIMEOUT_CYC cycles mid-word -> err=1. A byte arriving at exactly the expiry cycle
//    -> no err.
//  6 tx_busy held high 100 cycles in ACK -> tx_start fires on the first idle cycle.
//    Also: rstn low during DATA -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg: shared constants and state encoding for the LOAD receive path
package uart_loader_pkg;
  localparam logic [7:0] LOADER_ACK = 8'h55;
  typedef enum logic [2:0] {LD_IDLE, LD_LEN, LD_DATA, LD_ACK, LD_DONE, LD_ERR} loader_state_t;
endpackage

// File: rtl/uart_loader_byte_assembler.sv
// byte_assembler: MSB-first 8->32 shift register with a one-cycle word_valid after the 4th byte
module byte_assembler (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        word_valid
);
  logic [1:0] idx;
  always_ff @(posedge clk)
    if (!rstn || clr) begin
      word <= 32'd0;
      idx <= 2'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= in_valid && idx == 2'd3;
      if (in_valid) begin
        word <= {word[23:0], in_byte};
        idx <= idx + 2'd1;
      end
    end
endmodule

// File: rtl/uart_loader.sv
// uart_loader: collects length + program bytes from uart_rx, writes imem words, then ACKs via uart_tx
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int          ADDR_W      = 14,
  parameter logic [31:0] TIMEOUT_CYC = 32'd5000000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  input  logic              ferr,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [31:0]       word_cnt,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;
  loader_state_t st;
  logic [31:0] len, tcnt, word;
  logic wv, load, clr, bad, rx_ok, tmo;
  assign load = st == LD_LEN || st == LD_DATA;
  assign clr = start && (st == LD_IDLE || st == LD_DONE || st == LD_ERR);
  assign bad = load && rx_ready && ferr;
  assign rx_ok = load && rx_ready && !ferr;
  // an arriving byte always beats expiry in the same cycle
  assign tmo = load && !rx_ready && tcnt == TIMEOUT_CYC - 32'd1;
  assign imem_we = st == LD_DATA && wv && !bad;
  assign imem_addr = word_cnt[ADDR_W-1:0];
  assign imem_wdata = word;
  assign tx_start = st == LD_ACK && !tx_busy;
  assign tx_data = tx_start ? LOADER_ACK : 8'h00;
  assign busy = load || st == LD_ACK;
  assign done = st == LD_DONE;
  assign err = st == LD_ERR;
  byte_assembler u_asm (
    .clk(clk), .rstn(rstn), .clr(clr), .in_valid(rx_ok), .in_byte(rx_data),
    .word(word), .word_valid(wv)
  );
  always_ff @(posedge clk)
    if (!rstn) begin
      st <= LD_IDLE;
      len <= 32'd0;
      tcnt <= 32'd0;
      word_cnt <= 32'd0;
    end else if (clr) begin
      st <= LD_LEN;
      len <= 32'd0;
      tcnt <= 32'd0;
      word_cnt <= 32'd0;
    end else begin
      tcnt <= (load && !rx_ready) ? tcnt + 32'd1 : 32'd0;
      if (imem_we) word_cnt <= word_cnt + 32'd1;
      if (bad || tmo) st <= LD_ERR;
      else if (st == LD_LEN && wv) begin
        len <= word;
        st <= word == 32'd0 ? LD_ACK : {1'b0, word} > MAX_WORDS ? LD_ERR : LD_DATA;
      end
      else if (imem_we && word_cnt + 32'd1 == len) st <= LD_ACK;
      else if (tx_start) st <= LD_DONE;
    end
endmodule
